// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router packet source and sink.
// Latency: n/a (types, constants and header field helpers only).
// Backpressure: n/a.
// Contents: FSM state encoding, header field positions, payload limit,
//           header field extraction helpers.
package router_pkg;

  // Sink FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_HDR_CAP = 3'd2;
  localparam logic [2:0] ST_BODY    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    HDR     = ST_HDR,
    HDR_CAP = ST_HDR_CAP,
    BODY    = ST_BODY,
    DONE    = ST_DONE
  } state_t;

  // Header byte layout: {len[5:0], addr[1:0]}
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam int MAX_PAYLOAD = 63;

  // Remaining-byte counters must hold MAX_PAYLOAD payload bytes plus parity
  localparam int LEFT_W = $clog2(MAX_PAYLOAD + 2);

  typedef logic [HDR_LEN_MSB-HDR_LEN_LSB:0]   len_t;
  typedef logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] addr_t;
  typedef logic [LEFT_W-1:0]                  left_t;

  function automatic len_t hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic addr_t hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// 8-bit XOR accumulator with clear, load and enable.
// Latency: result visible one cycle after load/en.
// Backpressure: none; caller gates en.
// Ports: clk, rst (sync, active-high), clr (zero), load (acc=din),
//        en (acc^=din), din[7:0], acc[7:0]. Priority: rst/clr > load > en.
module router_parity_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= 8'h00;
    end else if (load) begin
      acc <= din;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/router_pkt_sink.sv
// Drains one router output port: header, payload, parity; checks parity and address.
// Latency: pkt_done/status appear one cycle after the parity byte is captured.
// Backpressure: hold or vld_out low stops new read issues; in-flight byte still captured.
// Ports: clk, rst (sync, active-high); vld_out, dout[7:0], hold from router port;
//        read_enb to router FIFO; pkt_done, pkt_len[5:0], parity_err, addr_err,
//        pkt_cnt, err_cnt, busy status. Optional SINK_TIMEOUT_EN adds a body
//        stall timeout (TIMEOUT parameter) and the timeout_err pulse output.
module router_pkt_sink
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ADDR = 2'd0,
  parameter int         CNT_W     = 16
`ifdef SINK_TIMEOUT_EN
  ,
  parameter int         TIMEOUT   = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_out,
  input  logic [7:0]       dout,
  input  logic             hold,
  output logic             read_enb,
  output logic             pkt_done,
  output logic [5:0]       pkt_len,
  output logic             parity_err,
  output logic             addr_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
`ifdef SINK_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam left_t            LEFT_ONE = 1;

  state_t     state, state_nxt;
  logic [7:0] hdr;
  left_t      issue_left, cap_left;
  logic       rd_d;
  logic [7:0] acc;
  logic       cap, last_cap, pkt_bad;
  logic       timeout_hit;

  // Only BODY reads are data bytes; the IDLE read is consumed by HDR.
  assign cap      = rd_d && (state == BODY);
  assign last_cap = cap && (cap_left == LEFT_ONE);
  assign pkt_bad  = (acc != dout) || (hdr_addr(hdr) != PORT_ADDR);

  assign pkt_done = (state == DONE);
  assign busy     = (state != IDLE);

`ifdef SINK_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_ONE = 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt;

  // Fires on the TIMEOUT-th consecutive idle, un-held body cycle.
  assign timeout_hit = (state == BODY) && !cap && !hold && (stall_cnt == STALL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state != BODY || cap) begin
        stall_cnt <= '0;
      end else if (!hold) begin
        stall_cnt <= stall_cnt + STALL_ONE;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  router_parity_acc u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (timeout_hit),
    .load (state == HDR),
    .en   (cap && (cap_left != LEFT_ONE)),
    .din  (dout),
    .acc  (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    read_enb  = 1'b0;
    case (state)
      IDLE: begin
        read_enb = vld_out && !hold;
        if (read_enb) state_nxt = HDR;
      end
      HDR:     state_nxt = HDR_CAP;
      HDR_CAP: state_nxt = BODY;
      BODY: begin
        read_enb = vld_out && !hold && (issue_left != '0);
        if (timeout_hit) begin
          state_nxt = IDLE;
        end else if (last_cap) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr        <= 8'h00;
      issue_left <= '0;
      cap_left   <= '0;
      rd_d       <= 1'b0;
      pkt_len    <= 6'd0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      rd_d <= read_enb;
      if (state == HDR) begin
        hdr        <= dout;
        issue_left <= left_t'(hdr_len(dout)) + LEFT_ONE;
        cap_left   <= left_t'(hdr_len(dout)) + LEFT_ONE;
      end
      if (state == BODY && read_enb) begin
        issue_left <= issue_left - LEFT_ONE;
      end
      if (cap) begin
        cap_left <= cap_left - LEFT_ONE;
      end
      // The parity byte is compared as it arrives, so status is ready in DONE.
      if (last_cap) begin
        pkt_len    <= hdr_len(hdr);
        parity_err <= (acc != dout);
        addr_err   <= (hdr_addr(hdr) != PORT_ADDR);
        pkt_cnt    <= pkt_cnt + CNT_ONE;
        if (pkt_bad) err_cnt <= err_cnt + CNT_ONE;
      end
      if (timeout_hit) begin
        hdr        <= 8'h00;
        issue_left <= '0;
        cap_left   <= '0;
        err_cnt    <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_sink.sv
// Self-checking bench for router_pkt_sink (PORT_ADDR=2).
// Models the router port FIFO as a byte queue with 1-cycle read latency.
// Checks table vectors, hand-timed corner cases and randomized traffic.
module tb_router_pkt_sink;

  localparam logic [1:0] PA = 2'd2;

  logic        clk, rst, vld_out, hold, read_enb;
  logic [7:0]  dout;
  logic        pkt_done, parity_err, addr_err, busy;
  logic [5:0]  pkt_len;
  logic [15:0] pkt_cnt, err_cnt;
`ifdef SINK_TIMEOUT_EN
  logic        timeout_err;
`endif

  router_pkt_sink #(.PORT_ADDR(PA), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .vld_out    (vld_out),
    .dout       (dout),
    .hold       (hold),
    .read_enb   (read_enb),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt),
    .busy       (busy)
`ifdef SINK_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] len;
    logic       perr;
    logic       aerr;
  } res_t;

  typedef struct {
    int         len;
    logic [1:0] addr;
    logic [7:0] flip;
    logic [5:0] exp_len;
    logic       exp_perr;
    logic       exp_aerr;
  } vec_t;

  logic [7:0]  q[$];
  res_t        exp_q[$];
  logic [15:0] m_pkt, m_err;
  bit          pending, hold_req, gate_req;
  int          n_reads, n_done, n_to, cyc, last_rd_cyc, done_cyc;
  int          n_chk, n_fail;
  logic [31:0] rd_hist;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: present read data for last cycle's strobe, drive vld/hold, observe.
  task automatic step();
    res_t e;
    @(negedge clk);
    if (pending && q.size() != 0) dout = q.pop_front();
    else dout = 8'($urandom);
    vld_out = (q.size() != 0) && !gate_req;
    hold    = hold_req;
    #1;
    cyc++;
    pending = read_enb;
    rd_hist = {rd_hist[30:0], read_enb};
    if (hold || !vld_out) chk("rd_while_blocked", {31'd0, read_enb}, 32'd0);
    if (read_enb) begin
      n_reads++;
      last_rd_cyc = cyc;
    end
`ifdef SINK_TIMEOUT_EN
    if (timeout_err) n_to++;
`endif
    if (pkt_done) begin
      done_cyc = cyc;
      n_done++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pkt_done: got pkt_done=1, expected none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        m_pkt++;
        if (e.perr || e.aerr) m_err++;
        chk("pkt_len", {26'd0, pkt_len}, {26'd0, e.len});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        chk("addr_err", {31'd0, addr_err}, {31'd0, e.aerr});
        chk("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, m_pkt});
        chk("err_cnt", {16'd0, err_cnt}, {16'd0, m_err});
      end
    end
  endtask

  // Pushes a packet into the port FIFO; r is the spec-rule outcome.
  task automatic push_pkt(input int len, input logic [1:0] addr, input logic [7:0] flip,
                          output res_t r);
    logic [7:0] h, p, b;
    h = {len[5:0], addr};
    p = h;
    q.push_back(h);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      p = p ^ b;
    end
    q.push_back(p ^ flip);
    r.len  = len[5:0];
    r.perr = (flip != 8'h00);
    r.aerr = (addr != PA);
  endtask

  task automatic wait_done(input int budget, input string name);
    int start, k;
    start = n_done;
    k = 0;
    while (n_done == start && k < budget) begin
      step();
      k++;
    end
    if (n_done == start) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no pkt_done, expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_pkt_done"}, {31'd0, pkt_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pkt_len"}, {26'd0, pkt_len}, 32'd0);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    chk({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    chk({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'd0);
    chk({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    res_t        r;
    int          r0, k, target;
    logic [20:0] exp_pat, got_pat;

    rst = 1'b1; vld_out = 1'b0; hold = 1'b0; dout = 8'h00;
    pending = 0; hold_req = 0; gate_req = 0;
    n_reads = 0; n_done = 0; n_to = 0; cyc = 0; last_rd_cyc = 0; done_cyc = 0;
    n_chk = 0; n_fail = 0; m_pkt = '0; m_err = '0; rd_hist = '0;

    vecs[0] = '{14, 2'd2, 8'h00, 6'd14, 1'b0, 1'b0};
    vecs[1] = '{14, 2'd2, 8'h01, 6'd14, 1'b1, 1'b0};
    vecs[2] = '{14, 2'd1, 8'h00, 6'd14, 1'b0, 1'b1};
    vecs[3] = '{0,  2'd2, 8'h00, 6'd0,  1'b0, 1'b0};
    vecs[4] = '{63, 2'd2, 8'h00, 6'd63, 1'b0, 1'b0};
    vecs[5] = '{3,  2'd0, 8'h80, 6'd3,  1'b1, 1'b1};
    vecs[6] = '{1,  2'd3, 8'h00, 6'd1,  1'b0, 1'b1};

    // Reset state
    step(); step();
    chk_idle_zero("reset");
    chk("reset_read_enb", {31'd0, read_enb}, 32'd0);
    rst = 1'b0;

    // Table vectors, vld_out held high (whole packet queued up front)
    for (int i = 0; i < 7; i++) begin
      r0 = n_reads;
      push_pkt(vecs[i].len, vecs[i].addr, vecs[i].flip, r);
      exp_q.push_back('{vecs[i].exp_len, vecs[i].exp_perr, vecs[i].exp_aerr});
      wait_done(300, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_reads", i), n_reads - r0, vecs[i].len + 2);
      chk($sformatf("vec%0d_done_gap", i), done_cyc - last_rd_cyc, 2);
      if (i == 0) begin
        // idle, header read, 2-cycle decode bubble, 15 back-to-back reads, capture, done
        exp_pat = 21'b0_1_00_111111111111111_00;
        got_pat = rd_hist[20:0];
        chk("vec0_read_pattern", {11'd0, got_pat}, {11'd0, exp_pat});
      end
      step();
      chk($sformatf("vec%0d_idle_after", i), {31'd0, busy}, 32'd0);
    end

    // len=5 with hold pulsed 3 cycles and vld_out gated 4 cycles mid-body
    r0 = n_reads;
    push_pkt(5, PA, 8'h00, r);
    exp_q.push_back(r);
    target = n_done + 1;
    k = 0;
    while (n_done < target && k < 100) begin
      hold_req = (k >= 5 && k < 8);
      gate_req = (k >= 9 && k < 13);
      step();
      k++;
    end
    hold_req = 0; gate_req = 0;
    if (n_done < target) chk("gap_pkt_done_seen", 0, 1);
    chk("gap_reads", n_reads - r0, 7);

    // Reset in BODY after 3 payload bytes: packet abandoned, counters cleared
    r0 = n_reads;
    push_pkt(8, PA, 8'h00, r);
    k = 0;
    while (n_reads - r0 < 4 && k < 50) begin
      step();
      k++;
    end
    step();
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    q.delete();
    step(); step();
    chk_idle_zero("rst_mid");
    m_pkt = '0; m_err = '0;
    rst = 1'b0;
    push_pkt(10, PA, 8'h00, r);
    exp_q.push_back(r);
    wait_done(100, "post_rst");

    // Randomized traffic against the packet-rule model
    for (int i = 0; i < 25; i++) begin
      push_pkt($urandom_range(0, 20), 2'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, r);
      exp_q.push_back(r);
    end
    target = n_done + 25;
    k = 0;
    while (n_done < target && k < 5000) begin
      hold_req = ($urandom_range(0, 3) == 0);
      gate_req = ($urandom_range(0, 4) == 0);
      step();
      k++;
    end
    hold_req = 0; gate_req = 0;
    chk("rand_pkts_done", n_done - (target - 25), 25);
    chk("rand_exp_drained", exp_q.size(), 0);

`ifdef SINK_TIMEOUT_EN
    // Starved body: header plus 2 of 5 payload bytes, then nothing
    q.push_back({6'd5, PA});
    q.push_back(8'h11);
    q.push_back(8'h22);
    r0 = n_done;
    n_to = 0;
    for (int i = 0; i < 60; i++) step();
    m_err++;
    chk("to_pulses", n_to, 1);
    chk("to_no_pkt_done", n_done - r0, 0);
    chk("to_err_cnt", {16'd0, err_cnt}, {16'd0, m_err});
    chk("to_busy", {31'd0, busy}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
